serial_subtractor: RTL and testbench

Bit-serial, LSB-first subtractor computing a − b − bin over WIDTH clock cycles with a start/busy/done handshake. It is the inverse-direction companion to the combinational carry-lookahead adder in the COMBINATIONAL library. It trades single-cycle latency for one full-subtractor cell plus a borrow flop. Results are checked against the adder: a = diff + b + bin (mod 2^WIDTH) with matching borrow/carry.

---
 rtl/serial_subtractor.sv | 130 +++++++++++++
 tb/tb_serial_subtractor.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial, LSB-first subtractor producing a - b - bin over WIDTH clock
//   cycles. A single full-subtractor cell processes one bit per cycle. A
//   borrow flop carries the borrow from bit to bit.
//
// Ports
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   start  : request; operands are sampled on the edge where start=1 and the
//            block is not busy (IDLE, or the DONE cycle)
//   a, b   : minuend / subtrahend, WIDTH bits, unsigned
//   bin    : borrow-in
//   busy   : high while a subtraction is in progress
//   done   : one-cycle completion pulse; diff/bout are valid from this cycle on
//   diff   : registered difference, a - b - bin mod 2^WIDTH
//   bout   : registered borrow-out (1 when a < b + bin, unsigned)
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sr;
  logic             br;
  logic [CW-1:0]    cnt;

  logic             d;
  logic             br_next;

  // Full-subtractor cell working on the current LSBs of the operand shifters.
  always_comb begin
    d       = sa[0] ^ sb[0] ^ br;
    br_next = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
  end

  // Control FSM and datapath registers. diff/bout are written only on the
  // completion edge. Partial results therefore never show on the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      sa    <= '0;
      sb    <= '0;
      sr    <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            sa    <= a;
            sb    <= b;
            br    <= bin;
            sr    <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          // start is deliberately ignored here; the request is not queued.
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          br  <= br_next;
          sr  <= {d, sr[WIDTH-1:1]};
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            // The last bit is still in d, not yet in sr, so it is merged here.
            diff  <= {d, sr[WIDTH-1:1]};
            bout  <= br_next;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end

        S_DONE: begin
          // A start request in the done cycle chains directly into the next
          // operation. No IDLE cycle sits between the two operations.
          if (start) begin
            sa    <= a;
            sb    <= b;
            br    <= bin;
            sr    <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            done  <= 1'b0;
            state <= S_SHIFT;
          end else begin
            done  <= 1'b0;
            state <= S_IDLE;
          end
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
//   Bench for serial_subtractor. Two instances are used: WIDTH=4 and WIDTH=8.
//   A cycle-level reference model built from plain arithmetic follows each
//   instance. The model counts WIDTH edges from acceptance and then presents
//   (a - b - bin) mod 2^WIDTH. One compare process checks every instance output
//   against its model on each falling edge. Directed vectors with hand-worked
//   results pin the model and the design.
module tb_serial_subtractor;

  logic       clk;
  logic       rst_n;

  logic       start4;
  logic [3:0] a4;
  logic [3:0] b4;
  logic       bin4;
  logic       busy4;
  logic       done4;
  logic [3:0] diff4;
  logic       bout4;

  logic       start8;
  logic [7:0] a8;
  logic [7:0] b8;
  logic       bin8;
  logic       busy8;
  logic       done8;
  logic [7:0] diff8;
  logic       bout8;

  int checks   = 0;
  int failures = 0;

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start4),
    .a    (a4),
    .b    (b4),
    .bin  (bin4),
    .busy (busy4),
    .done (done4),
    .diff (diff4),
    .bout (bout4)
  );

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start8),
    .a    (a8),
    .b    (b8),
    .bin  (bin8),
    .busy (busy8),
    .done (done8),
    .diff (diff8),
    .bout (bout8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: remaining-edge countdown plus the arithmetic result.
  logic       mBusy4 = 1'b0;
  logic       mDone4 = 1'b0;
  logic [3:0] mDiff4 = '0;
  logic       mBout4 = 1'b0;
  logic [3:0] pDiff4 = '0;
  logic       pBout4 = 1'b0;
  int         rem4   = 0;

  logic       mBusy8 = 1'b0;
  logic       mDone8 = 1'b0;
  logic [7:0] mDiff8 = '0;
  logic       mBout8 = 1'b0;
  logic [7:0] pDiff8 = '0;
  logic       pBout8 = 1'b0;
  int         rem8   = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mBusy4 = 1'b0; mDone4 = 1'b0; mDiff4 = '0; mBout4 = 1'b0; rem4 = 0;
      mBusy8 = 1'b0; mDone8 = 1'b0; mDiff8 = '0; mBout8 = 1'b0; rem8 = 0;
    end else begin
      if (mBusy4) begin
        rem4 = rem4 - 1;
        if (rem4 == 0) begin
          mBusy4 = 1'b0; mDone4 = 1'b1; mDiff4 = pDiff4; mBout4 = pBout4;
        end
      end else begin
        mDone4 = 1'b0;
        if (start4) begin
          pDiff4 = a4 - b4 - {3'b0, bin4};
          pBout4 = ({1'b0, a4} < ({1'b0, b4} + {4'b0, bin4}));
          mBusy4 = 1'b1;
          rem4   = 4;
        end
      end
      if (mBusy8) begin
        rem8 = rem8 - 1;
        if (rem8 == 0) begin
          mBusy8 = 1'b0; mDone8 = 1'b1; mDiff8 = pDiff8; mBout8 = pBout8;
        end
      end else begin
        mDone8 = 1'b0;
        if (start8) begin
          pDiff8 = a8 - b8 - {7'b0, bin8};
          pBout8 = ({1'b0, a8} < ({1'b0, b8} + {8'b0, bin8}));
          mBusy8 = 1'b1;
          rem8   = 8;
        end
      end
    end
  end

  // Compare process: every falling edge, both instances against the model.
  always @(negedge clk) begin
    checks = checks + 1;
    if ({busy4, done4, diff4, bout4} !== {mBusy4, mDone4, mDiff4, mBout4}) begin
      failures = failures + 1;
      $display("[TB] FAIL model4 t=%0t got busy=%b done=%b diff=%h bout=%b expected busy=%b done=%b diff=%h bout=%b",
               $time, busy4, done4, diff4, bout4, mBusy4, mDone4, mDiff4, mBout4);
    end
    checks = checks + 1;
    if ({busy8, done8, diff8, bout8} !== {mBusy8, mDone8, mDiff8, mBout8}) begin
      failures = failures + 1;
      $display("[TB] FAIL model8 t=%0t got busy=%b done=%b diff=%h bout=%b expected busy=%b done=%b diff=%h bout=%b",
               $time, busy8, done8, diff8, bout8, mBusy8, mDone8, mDiff8, mBout8);
    end
    checks = checks + 1;
    if ((busy4 & done4) || (busy8 & done8)) begin
      failures = failures + 1;
      $display("[TB] FAIL busy_done_overlap t=%0t got busy4=%b done4=%b busy8=%b done8=%b expected no overlap",
               $time, busy4, done4, busy8, done8);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("[TB] FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Pulse start for one cycle on the 4-bit instance and wait for done.
  task automatic applyStimulus(input logic [3:0] opA, input logic [3:0] opB, input logic opBin,
                               output int lat, output int busyCnt);
    @(negedge clk);
    a4 = opA; b4 = opB; bin4 = opBin; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    a4 = 4'($urandom); b4 = 4'($urandom); bin4 = 1'($urandom);
    lat = 0;
    busyCnt = 0;
    while (!done4 && lat < 20) begin
      if (busy4) busyCnt = busyCnt + 1;
      @(negedge clk);
      lat = lat + 1;
    end
    checkOutput("done4_seen", 32'(done4), 32'd1);
  endtask

  task automatic runCase4(input string name, input logic [3:0] opA, input logic [3:0] opB,
                          input logic opBin, input logic [3:0] expDiff, input logic expBout);
    int lat;
    int busyCnt;
    logic [4:0] sum;
    applyStimulus(opA, opB, opBin, lat, busyCnt);
    checkOutput({name, "_diff"}, 32'(diff4), 32'(expDiff));
    checkOutput({name, "_bout"}, 32'(bout4), 32'(expBout));
    // Adder cross-check: diff + b + bin must give back a, with carry = bout.
    sum = {1'b0, diff4} + {1'b0, opB} + {4'b0, opBin};
    checkOutput({name, "_add_sum"}, 32'(sum[3:0]), 32'(opA));
    checkOutput({name, "_add_cout"}, 32'(sum[4]), 32'(bout4));
  endtask

  task automatic runOp8(input logic [7:0] opA, input logic [7:0] opB, input logic opBin);
    int n;
    @(negedge clk);
    a8 = opA; b8 = opB; bin8 = opBin; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    n = 0;
    while (!done8 && n < 30) begin
      @(negedge clk);
      n = n + 1;
    end
    checkOutput("done8_seen", 32'(done8), 32'd1);
  endtask

  task automatic waitDone4(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n = n + 1;
    end while (!done4 && n < 20);
    checkOutput("done4_wait", 32'(done4), 32'd1);
  endtask

  initial begin
    int lat;
    int busyCnt;
    int n;
    logic [3:0] hA [3];
    logic [3:0] hB [3];
    logic       hBin [3];
    logic [3:0] hDiff [3];
    logic       hBout [3];

    rst_n = 1'b1;
    start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset_busy", 32'(busy4), 32'd0);
    checkOutput("reset_done", 32'(done4), 32'd0);
    checkOutput("reset_diff", 32'(diff4), 32'd0);
    checkOutput("reset_bout", 32'(bout4), 32'd0);
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;

    // First operation: latency and busy length.
    applyStimulus(4'd2, 4'd5, 1'b1, lat, busyCnt);
    checkOutput("first_latency", 32'(lat), 32'd4);
    checkOutput("first_busy_cycles", 32'(busyCnt), 32'd4);
    checkOutput("first_diff", 32'(diff4), 32'hC);
    checkOutput("first_bout", 32'(bout4), 32'd1);

    runCase4("v7_8_0",   4'd7,  4'd8,  1'b0, 4'hF, 1'b1);
    runCase4("v4_6_1",   4'd4,  4'd6,  1'b1, 4'hD, 1'b1);
    runCase4("v11_6_0",  4'd11, 4'd6,  1'b0, 4'h5, 1'b0);
    runCase4("c0_0_1",   4'd0,  4'd0,  1'b1, 4'hF, 1'b1);
    runCase4("c15_15_0", 4'd15, 4'd15, 1'b0, 4'h0, 1'b0);
    runCase4("c15_0_0",  4'd15, 4'd0,  1'b0, 4'hF, 1'b0);
    runCase4("c0_15_1",  4'd0,  4'd15, 1'b1, 4'h0, 1'b1);

    // Exhaustive 4-bit sweep; the compare process checks each cycle.
    for (int ia = 0; ia < 16; ia++)
      for (int ib = 0; ib < 16; ib++)
        for (int ic = 0; ic < 2; ic++)
          applyStimulus(4'(ia), 4'(ib), 1'(ic), lat, busyCnt);

    // Start held high: a result every WIDTH+1 cycles, operands re-sampled.
    hA[0] = 4'd6;  hB[0] = 4'd2;  hBin[0] = 1'b0; hDiff[0] = 4'd4; hBout[0] = 1'b0;
    hA[1] = 4'd3;  hB[1] = 4'd9;  hBin[1] = 1'b1; hDiff[1] = 4'd9; hBout[1] = 1'b1;
    hA[2] = 4'd12; hB[2] = 4'd12; hBin[2] = 1'b0; hDiff[2] = 4'd0; hBout[2] = 1'b0;
    @(negedge clk);
    a4 = hA[0]; b4 = hB[0]; bin4 = hBin[0]; start4 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      waitDone4(n);
      if (k > 0) checkOutput("held_period", 32'(n), 32'd5);
      checkOutput("held_diff", 32'(diff4), 32'(hDiff[k]));
      checkOutput("held_bout", 32'(bout4), 32'(hBout[k]));
      if (k < 2) begin
        a4 = hA[k+1]; b4 = hB[k+1]; bin4 = hBin[k+1];
      end else begin
        start4 = 1'b0;
      end
    end

    // start during SHIFT is ignored: the result belongs to the first operands.
    @(negedge clk);
    @(negedge clk);
    a4 = 4'd10; b4 = 4'd3; bin4 = 1'b0; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    a4 = 4'd1; b4 = 4'd14; bin4 = 1'b1; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    n = 0;
    while (!done4 && n < 20) begin
      @(negedge clk);
      n = n + 1;
    end
    checkOutput("ignore_done", 32'(done4), 32'd1);
    checkOutput("ignore_diff", 32'(diff4), 32'd7);
    checkOutput("ignore_bout", 32'(bout4), 32'd0);

    // Asynchronous reset in the middle of SHIFT.
    @(negedge clk);
    @(negedge clk);
    a4 = 4'd13; b4 = 4'd2; bin4 = 1'b0; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    checkOutput("pre_abort_busy", 32'(busy4), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", 32'(busy4), 32'd0);
    checkOutput("abort_done", 32'(done4), 32'd0);
    checkOutput("abort_diff", 32'(diff4), 32'd0);
    checkOutput("abort_bout", 32'(bout4), 32'd0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("abort_no_done", 32'(done4), 32'd0);
    #1 rst_n = 1'b1;
    runCase4("after_reset", 4'd9, 4'd3, 1'b0, 4'h6, 1'b0);

    // 8-bit instance: two pinned vectors, then random vectors.
    runOp8(8'h10, 8'h01, 1'b0);
    checkOutput("w8_diff_a", 32'(diff8), 32'h0F);
    checkOutput("w8_bout_a", 32'(bout8), 32'd0);
    runOp8(8'h00, 8'hFF, 1'b0);
    checkOutput("w8_diff_b", 32'(diff8), 32'h01);
    checkOutput("w8_bout_b", 32'(bout8), 32'd1);
    for (int i = 0; i < 1000; i++)
      runOp8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));

    @(negedge clk);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
